// File: rtl/tdm_pkg.sv
// Shared definitions for the 4:1 TDM link.
// The rotating transmit mux and the tdm_demux_four receiver both import this package.
package tdm_pkg;

    localparam int unsigned SLOTS      = 4;
    localparam int unsigned SLOT_IDX_W = 2;

    typedef logic [SLOT_IDX_W-1:0] slot_idx_t;

    localparam slot_idx_t SLOT_A = 2'd0;
    localparam slot_idx_t SLOT_B = 2'd1;
    localparam slot_idx_t SLOT_C = 2'd2;
    localparam slot_idx_t SLOT_D = 2'd3;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_e;

    // Slot that follows s in the rotation; index 3 wraps back to 0.
    function automatic slot_idx_t slot_next(input slot_idx_t s);
        return s + SLOT_IDX_W'(1);
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// 2-bit wrapping slot counter with enable and synchronous load-to-1.
// The transmitter uses the same counter, so both ends of the link rotate identically.
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  logic      load1,
    output slot_idx_t cnt
);

    slot_idx_t cnt_q;
    slot_idx_t cnt_d;

    // load1 wins over en; both cases move the counter to slot B after a slot-0 beat.
    always_comb begin
        cnt_d = cnt_q;
        if (load1) begin
            cnt_d = SLOT_B;
        end else if (en) begin
            cnt_d = slot_next(cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= SLOT_A;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/tdm_demux_four.sv
// Receive end of the 4:1 TDM link: tracks the slot rotation, reassembles each
// frame and presents channels a..d in parallel with lock and alignment status.
module tdm_demux_four
    import tdm_pkg::*;
#(
    parameter int unsigned DATA_W   = 1,
    parameter int unsigned MISS_MAX = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              fsync,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] d,
    output logic              s1,
    output logic              s0,
    output logic              frame_valid,
    output logic              locked,
    output logic              sync_err
);

    localparam int unsigned MISS_W = 3;
    localparam int unsigned STG_N  = SLOTS - 1;

    state_e                             state_q, state_d;
    logic [STG_N-1:0][DATA_W-1:0]       stg_q, stg_d;
    logic [SLOTS-1:0][DATA_W-1:0]       out_q, out_d;
    logic [MISS_W-1:0]                  miss_q, miss_d;
    logic [MISS_W-1:0]                  miss_inc;
    logic                               frame_valid_q, frame_valid_d;
    logic                               sync_err_q, sync_err_d;
    logic                               locked_q, locked_d;
    logic                               cnt_en, cnt_load1;
    slot_idx_t                          slot;

    tdm_slot_counter u_slot_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (cnt_en),
        .load1 (cnt_load1),
        .cnt   (slot)
    );

    assign miss_inc = miss_q + MISS_W'(1);

    // Beat handling; with din_valid low only the one-cycle pulses fall back to 0.
    always_comb begin
        state_d       = state_q;
        stg_d         = stg_q;
        out_d         = out_q;
        miss_d        = miss_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        cnt_en        = 1'b0;
        cnt_load1     = 1'b0;

        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (fsync) begin
                        stg_d[0]  = din;
                        miss_d    = '0;
                        cnt_load1 = 1'b1;
                        state_d   = LOCK;
                    end
                end
                LOCK: begin
                    if (fsync) begin
                        // Resync on every fsync; off slot 0 the partial frame is discarded.
                        sync_err_d = (slot != SLOT_A);
                        stg_d[0]   = din;
                        miss_d     = '0;
                        cnt_load1  = 1'b1;
                    end else begin
                        unique case (slot)
                            SLOT_A: begin
                                // Flywheel through missing fsyncs until MISS_MAX in a row.
                                if (miss_inc >= MISS_W'(MISS_MAX)) begin
                                    miss_d  = '0;
                                    state_d = HUNT;
                                end else begin
                                    miss_d    = miss_inc;
                                    stg_d[0]  = din;
                                    cnt_load1 = 1'b1;
                                end
                            end
                            SLOT_B: begin
                                stg_d[1] = din;
                                cnt_en   = 1'b1;
                            end
                            SLOT_C: begin
                                stg_d[2] = din;
                                cnt_en   = 1'b1;
                            end
                            SLOT_D: begin
                                out_d         = {din, stg_q[2], stg_q[1], stg_q[0]};
                                frame_valid_d = 1'b1;
                                cnt_en        = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        locked_d = (state_d == LOCK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HUNT;
            stg_q         <= '0;
            out_q         <= '0;
            miss_q        <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            stg_q         <= stg_d;
            out_q         <= out_d;
            miss_q        <= miss_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            locked_q      <= locked_d;
        end
    end

    assign a           = out_q[0];
    assign b           = out_q[1];
    assign c           = out_q[2];
    assign d           = out_q[3];
    assign s1          = slot[1];
    assign s0          = slot[0];
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_tdm_demux_four.sv
// Self-checking bench for tdm_demux_four: directed scenarios then random beats,
// all compared each cycle against a frame-level reference model.
module tb_tdm_demux_four;

    localparam int unsigned DW = 4;
    localparam int          MM = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          fsync;
    logic [DW-1:0] a, b, c, d;
    logic          s1, s0, frame_valid, locked, sync_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit            m_lock;
    int            m_slot;
    int            m_miss;
    logic [DW-1:0] m_stg [3];
    logic [DW-1:0] m_out [4];
    bit            m_fv;
    bit            m_se;

    tdm_demux_four #(.DATA_W(DW), .MISS_MAX(MM)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .fsync       (fsync),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .s1          (s1),
        .s0          (s0),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic model(input logic [DW-1:0] dv, input bit v, input bit f, input bit r);
        m_fv = 0;
        m_se = 0;
        if (r) begin
            m_lock = 0; m_slot = 0; m_miss = 0;
            for (int i = 0; i < 3; i++) m_stg[i] = '0;
            for (int i = 0; i < 4; i++) m_out[i] = '0;
        end else if (v) begin
            if (!m_lock) begin
                if (f) begin
                    m_stg[0] = dv; m_slot = 1; m_lock = 1; m_miss = 0;
                end
            end else if (f) begin
                m_se = (m_slot != 0);
                m_stg[0] = dv; m_slot = 1; m_miss = 0;
            end else if (m_slot == 0) begin
                m_miss++;
                if (m_miss >= MM) begin
                    m_lock = 0; m_miss = 0;
                end else begin
                    m_stg[0] = dv; m_slot = 1;
                end
            end else if (m_slot < 3) begin
                m_stg[m_slot] = dv;
                m_slot++;
            end else begin
                m_out[0] = m_stg[0]; m_out[1] = m_stg[1];
                m_out[2] = m_stg[2]; m_out[3] = dv;
                m_fv = 1;
                m_slot = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a",           32'(a),           32'(m_out[0]));
        chk("b",           32'(b),           32'(m_out[1]));
        chk("c",           32'(c),           32'(m_out[2]));
        chk("d",           32'(d),           32'(m_out[3]));
        chk("slot",        32'({s1, s0}),    32'(m_slot));
        chk("frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("locked",      32'(locked),      32'(m_lock));
        chk("sync_err",    32'(sync_err),    32'(m_se));
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after it.
    task automatic beat(input logic [DW-1:0] dv, input bit v, input bit f, input bit r);
        din = dv; din_valid = v; fsync = f; rst = r;
        @(posedge clk);
        model(dv, v, f, r);
        #1;
        check_all();
    endtask

    task automatic frame(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                         input logic [DW-1:0] w2, input logic [DW-1:0] w3, input bit f);
        beat(w0, 1, f, 0);
        beat(w1, 1, 0, 0);
        beat(w2, 1, 0, 0);
        beat(w3, 1, 0, 0);
    endtask

    initial begin
        rst = 1'b1; din = '0; din_valid = 1'b0; fsync = 1'b0;
        model('0, 0, 0, 1);
        beat('0, 0, 0, 1);
        beat('0, 0, 0, 1);

        // Basic frame 1,0,0,1 with literal expectations
        frame(4'h1, 4'h0, 4'h0, 4'h1, 1);
        chk("s1_a",  32'(a), 32'h1);
        chk("s1_b",  32'(b), 32'h0);
        chk("s1_c",  32'(c), 32'h0);
        chk("s1_d",  32'(d), 32'h1);
        chk("s1_fv", 32'(frame_valid), 32'h1);
        chk("s1_lk", 32'(locked), 32'h1);
        chk("s1_sl", 32'({s1, s0}), 32'h0);
        beat('0, 0, 0, 0);
        chk("s1_fv_pulse", 32'(frame_valid), 32'h0);

        // Back-to-back frames
        frame(4'h0, 4'h1, 4'h1, 4'h1, 1);
        frame(4'h1, 4'h1, 4'h0, 4'h1, 1);
        chk("b2b_d", 32'({a, b, c, d}), 32'h1101);

        // Valid gap between slot 1 and slot 2
        beat(4'h5, 1, 1, 0);
        beat(4'h6, 1, 0, 0);
        repeat (3) begin
            beat(4'h9, 0, 0, 0);
            chk("gap_slot", 32'({s1, s0}), 32'h2);
        end
        beat(4'h7, 1, 0, 0);
        beat(4'h8, 1, 0, 0);
        chk("gap_out", 32'({a, b, c, d}), 32'h5678);

        // Misaligned fsync on slot 2
        beat(4'hA, 1, 1, 0);
        beat(4'hB, 1, 0, 0);
        beat(4'hC, 1, 1, 0);
        chk("mis_se",  32'(sync_err), 32'h1);
        chk("mis_out", 32'({a, b, c, d}), 32'h5678);
        beat(4'hD, 1, 0, 0);
        beat(4'hE, 1, 0, 0);
        beat(4'hF, 1, 0, 0);
        chk("mis_new", 32'({a, b, c, d}), 32'hCDEF);

        // Flywheel then loss of lock, then relock
        frame(4'h2, 4'h3, 4'h4, 4'h5, 0);
        chk("fly_out", 32'({a, b, c, d}), 32'h2345);
        beat(4'h6, 1, 0, 0);
        chk("fly_lost", 32'(locked), 32'h0);
        frame(4'h1, 4'h2, 4'h3, 4'h4, 0);
        frame(4'h9, 4'h8, 4'h7, 4'h6, 1);
        chk("relock", 32'({a, b, c, d}), 32'h9876);

        // Reset mid-frame
        beat(4'h1, 1, 1, 0);
        beat(4'h2, 1, 0, 0);
        beat(4'h3, 1, 0, 0);
        beat(4'h4, 1, 0, 1);
        chk("rst_out", 32'({a, b, c, d, locked, s1, s0}), 32'h0);
        frame(4'h3, 4'hC, 4'h5, 4'hA, 1);
        chk("rst_frame", 32'({a, b, c, d}), 32'h3C5A);

        // Random beats against the model
        for (int i = 0; i < 1500; i++) begin
            beat(DW'($urandom), ($urandom % 4) != 0, ($urandom % 5) == 0,
                 ($urandom % 150) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux_four.md
Name: tdm_demux_four

Overview:
- Receive end of the 4:1 time-division link: one data line carries slots a, b, c, d in rotation (slot index s1:s0 = 0,1,2,3), with a frame-sync strobe marking slot 0.
- Tracks the slot rotation with an internal counter, reassembles each frame, and presents the four channels in parallel, registered.
- Sits downstream of the team's rotating 4:1 multiplexer; together the two blocks form a loopback pair.

Parameters:
- DATA_W, 1, bits per slot: width of din and of each channel output.
- MISS_MAX, 2, consecutive missing fsyncs (at 1..7) that drop lock and return to HUNT.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- din  input  DATA_W  slot data
- din_valid  input  1  beat qualifier; a beat is accepted only when high
- fsync  input  1  frame sync; qualified by din_valid; marks slot 0
- a  output  DATA_W  channel 0, slot s1:s0=00
- b  output  DATA_W  channel 1, slot 01
- c  output  DATA_W  channel 2, slot 10
- d  output  DATA_W  channel 3, slot 11
- s1  output  1  MSB of the next expected slot index
- s0  output  1  LSB of the next expected slot index
- frame_valid  output  1  one-cycle pulse: a..d hold a new complete frame
- locked  output  1  high in LOCK state
- sync_err  output  1  one-cycle pulse: fsync arrived at a non-zero slot

Behaviour:
- Reset values (rst sampled high at a clock edge, takes priority over every other input):
  - a, b, c, d = 0
  - slot counter = 0, so s1 = 0 and s0 = 0
  - frame_valid = 0, sync_err = 0, locked = 0
  - miss counter = 0, staging registers = 0
  - state = HUNT
- Reset mid-frame discards the partial frame; a..d return to 0.
- Beats: din_valid = 0 means no state, counter, or output change, except that the frame_valid and sync_err pulses clear.
- FSM states: HUNT, LOCK.
- HUNT:
  - Beats without fsync are ignored.
  - A beat with fsync is stored as slot 0; counter becomes 1; go to LOCK; locked = 1 from the next cycle.
- LOCK, beat at counter 1 or 2 without fsync: store into staging[counter]; counter increments.
- LOCK, beat at counter 3 without fsync:
  - At that edge, a, b, c, d load staging0, staging1, staging2 and din.
  - frame_valid is high for exactly the next cycle. Latency from the slot-3 beat is 1 clock.
  - counter wraps to 0.
- LOCK, beat at counter 0 with fsync: store as slot 0; miss counter clears; counter = 1.
- LOCK, beat at counter 0 without fsync (flywheel):
  - Miss counter increments.
  - If it reaches MISS_MAX: go to HUNT, counter = 0, beat discarded, locked = 0 next cycle.
  - Otherwise the beat is accepted as slot 0.
- LOCK, beat at counter 1..3 with fsync (misalignment):
  - sync_err pulses one cycle and the partial frame is discarded; a..d keep their previous values; no frame_valid.
  - The beat is stored as slot 0; counter = 1; miss counter clears; stay in LOCK.
- Counter is 2 bits, wraps 3 to 0; {s1,s0} always equals the counter value.
- a..d change only on frame completion or reset.
- frame_valid and sync_err never assert in the same cycle.

Decomposition:
- Shared package tdm_pkg:
  - state enum {HUNT, LOCK}
  - SLOTS = 4, SLOT_IDX_W = 2
  - slot index constants SLOT_A..SLOT_D
  - the same package is used by the transmit-side 4:1 mux.
- One sub-module is natural: tdm_slot_counter, a 2-bit wrapping counter with enable and synchronous load-to-1. It drives s1/s0 and is reused by the transmitter.
- Staging, the output registers and the FSM stay in tdm_demux_four.

Test Plan:
- Reset, then fsync beat din=1, followed by beats 0, 0, 1 -> cycle after the 4th beat: a=1, b=0, c=0, d=1, frame_valid=1 for one cycle, locked=1, s1s0=00.
- Two back-to-back frames {0,1,1,1} then {1,1,0,1} with din_valid held high -> frame_valid pulses 4 cycles apart; a..d = 0,1,1,1, then 1,1,0,1.
- din_valid low for 3 cycles between slot 1 and slot 2 -> counter holds at 2; frame completes correctly with no extra frame_valid.
- fsync asserted on slot 2 of a frame -> sync_err pulse; a..d unchanged; next 3 beats complete a new frame from that beat; locked stays 1.
- With MISS_MAX=2, two consecutive frames sent without fsync -> first is accepted (flywheel, frame_valid pulses); at the second, locked falls and the beat is discarded; a later fsync beat relocks.
- rst asserted after slot 2 -> next cycle a..d = 0, locked = 0, s1s0 = 00; a following full frame with fsync decodes correctly.
